// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// Also consumed by the bench, so both agree on the state encoding.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } muldiv_state_e;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    // OP major opcode; funct7 = 0000001 selects the M extension
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
               (f3 == MULDIV_DIV)  || (f3 == MULDIV_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == MULDIV_MULH) || (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit bundle.
// Handshake: start is accepted only when the unit is idle and flush is low
// (no ready signal; stall tells the pipeline to hold). done is a one-cycle
// pulse with result/rd_out valid and has no backpressure.
interface muldiv_if #(
    parameter int XLEN                = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
);
    logic                           flush;
    logic                           start;
    logic [2:0]                     funct3;
    logic [XLEN-1:0]                rs1_val;
    logic [XLEN-1:0]                rs2_val;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_in;
    logic                           stall;
    logic                           busy;
    logic                           done;
    logic [XLEN-1:0]                result;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_out;

    modport master (
        output flush, start, funct3, rs1_val, rs2_val, rd_in,
        input  stall, busy, done, result, rd_out
    );

    modport slave (
        input  flush, start, funct3, rs1_val, rs2_val, rd_in,
        output stall, busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_fixup.sv
// Combinational sign correction and result selection for the multiply/divide
// unit: operates on unsigned magnitudes plus the latched operand sign flags.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quot,
    input  logic [XLEN-1:0]   rem,
    input  logic              sign1,
    input  logic              sign2,
    output logic [XLEN-1:0]   sel
);
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        prod_fix = (sign1 ^ sign2) ? -prod : prod;
        quot_fix = (sign1 ^ sign2) ? -quot : quot;
        // remainder takes the dividend's sign
        rem_fix  = sign1 ? -rem : rem;
        case (funct3)
            MULDIV_MUL:                             sel = prod_fix[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: sel = prod_fix[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                sel = quot_fix;
            default:                                sel = rem_fix;
        endcase
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; default is shift-add.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN                = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_if.slave       bus,
    output muldiv_state_e state_dbg
);
    localparam int              CNT_W    = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);

    muldiv_state_e                  state_q, state_d;
    logic [2:0]                     funct3_q;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
    logic                           sign1_q, sign2_q;
    logic [XLEN-1:0]                a_q, b_q;
    logic [2*XLEN-1:0]              acc_q;
    logic [XLEN-1:0]                quot_q, rem_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [XLEN-1:0]                result_q;

    logic              accept, s1, s2, div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, rem_next, diff, fix_sel;
    logic [XLEN:0]     shifted;
    logic              borrow;
`ifndef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     sum;
`else
    logic signed [XLEN:0] fa, fb;
`endif

    assign accept = (state_q == IDLE) && bus.start && !bus.flush;

    // Accept-cycle operand conditioning and divide special cases
    always_comb begin
        s1          = rs1_is_signed(bus.funct3) & bus.rs1_val[XLEN-1];
        s2          = rs2_is_signed(bus.funct3) & bus.rs2_val[XLEN-1];
        a_mag       = s1 ? -bus.rs1_val : bus.rs1_val;
        b_mag       = s2 ? -bus.rs2_val : bus.rs2_val;
        div_zero    = (bus.rs2_val == '0);
        div_ovf     = !bus.funct3[0] && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (&bus.rs2_val);
        special     = bus.funct3[2] && (div_zero || div_ovf);
        special_res = div_zero ? (bus.funct3[1] ? bus.rs1_val : '1)
                               : (bus.funct3[1] ? '0 : bus.rs1_val);
`ifdef MULDIV_FAST_MUL_EN
        fa = {rs1_is_signed(bus.funct3) & bus.rs1_val[XLEN-1], bus.rs1_val};
        fb = {rs2_is_signed(bus.funct3) & bus.rs2_val[XLEN-1], bus.rs2_val};
`endif
    end

    // One iteration of each datapath
    always_comb begin
`ifndef MULDIV_FAST_MUL_EN
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
`endif
        shifted  = {rem_q, quot_q[XLEN-1]};
        borrow   = shifted < {1'b0, b_q};
        diff     = shifted[XLEN-1:0] - b_q;
        rem_next = borrow ? shifted[XLEN-1:0] : diff;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.funct3[2])
                        state_d = special ? DONE : DIV;
                    else
`ifdef MULDIV_FAST_MUL_EN
                        state_d = FIXUP;
`else
                        state_d = MUL;
`endif
                end
            end
`ifndef MULDIV_FAST_MUL_EN
            MUL:     state_d = (cnt_q == CNT_W'(1)) ? FIXUP : MUL;
`endif
            DIV:     state_d = (cnt_q == CNT_W'(1)) ? FIXUP : DIV;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= '0;
            rd_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            funct3_q <= bus.funct3;
            rd_q     <= bus.rd_in;
            a_q      <= a_mag;
            b_q      <= b_mag;
            quot_q   <= a_mag;
            rem_q    <= '0;
            cnt_q    <= CNT_LOAD;
`ifdef MULDIV_FAST_MUL_EN
            // signed product is already exact; fixup must not negate it
            sign1_q  <= bus.funct3[2] & s1;
            sign2_q  <= bus.funct3[2] & s2;
            acc_q    <= (2*XLEN)'(fa * fb);
`else
            sign1_q  <= s1;
            sign2_q  <= s2;
            acc_q    <= {{XLEN{1'b0}}, b_mag};
`endif
            if (special)
                result_q <= special_res;
        end else begin
            case (state_q)
`ifndef MULDIV_FAST_MUL_EN
                MUL: begin
                    acc_q <= {sum, acc_q[XLEN-1:1]};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
`endif
                DIV: begin
                    rem_q  <= rem_next;
                    quot_q <= {quot_q[XLEN-2:0], ~borrow};
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
                FIXUP: if (!bus.flush) result_q <= fix_sel;
                default: ;
            endcase
        end
    end

    muldiv_fixup #(.XLEN(XLEN)) u_fixup (
        .funct3 (funct3_q),
        .prod   (acc_q),
        .quot   (quot_q),
        .rem    (rem_q),
        .sign1  (sign1_q),
        .sign2  (sign2_q),
        .sel    (fix_sel)
    );

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE) && !bus.flush;
    assign bus.stall  = accept || ((state_q != IDLE) && (state_q != DONE));
    assign bus.result = result_q;
    assign bus.rd_out = rd_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M/RV64M multiply-divide unit that sits beside the ALU in the EX stage of the five-stage core. It accepts forwarded operands when EX decodes an M-extension instruction and stalls the front of the pipeline while it iterates. It returns a one-cycle result pulse, together with the destination register, for the EX/MEM register to capture. It generalises the single-cycle EX datapath: operand width is parametrised, it has multi-cycle behaviour, and it covers the signed/unsigned and high/low result modes.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64)
- REGISTER_ADDR_WIDTH, 5, destination register index width

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  kill in-flight operation (branch/jalr redirect)
- start  input  1  EX holds an M-extension instruction this cycle
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  XLEN  forwarded rs1 operand
- rs2_val  input  XLEN  forwarded rs2 operand
- rd_in  input  REGISTER_ADDR_WIDTH  destination register
- stall  output  1  freeze PC, IF/ID and ID/EX
- busy  output  1  state != IDLE
- done  output  1  result valid, one-cycle pulse
- result  output  XLEN  operation result, valid when done=1
- rd_out  output  REGISTER_ADDR_WIDTH  latched rd_in, valid when done=1

## Operation
- The FSM has five states: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE with start=1 and flush=0 is the accept cycle. The unit latches funct3 and rd_in. It latches operand magnitudes and sign flags: signed for MULH/DIV/REM, rs1 only for MULHSU, none for the U variants and MUL.
- Next state after accept: MUL for funct3[2]=0, DIV for funct3[2]=1.
- Special cases go straight to DONE with no iteration:
  - Divide by zero: quotient = all-ones, remainder = rs1.
  - Signed overflow (DIV/REM of most-negative value by -1): quotient = rs1, remainder = 0.
- MUL state: XLEN iterations of unsigned shift-add into a 2*XLEN accumulator.
- DIV state: XLEN iterations of restoring division (quotient, XLEN+1-bit partial remainder).
- Iteration counter is $clog2(XLEN)+1 bits wide, loaded at accept and decremented each iteration. Exit to FIXUP when the counter reaches 0.
- FIXUP:
  - Negate the product when the operand signs differ.
  - Quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1).
  - Select low XLEN bits (MUL), high XLEN bits (MULH*), quotient or remainder. Register the selection into result.
- DONE: done=1 and rd_out valid; next state IDLE.
- stall = (IDLE & start & ~flush) | (busy & state != DONE). The pipeline advances in the DONE cycle.
- start while busy is ignored.
- flush in any state: next state IDLE, done stays 0 and no result is produced. flush in IDLE overrides start.
- Reset: state IDLE; done, busy, stall 0; result 0; rd_out 0; counter 0. Reset mid-operation discards the operation.

## Timing
Cycle 0 is the accept cycle. Latencies are measured as the cycle in which done=1.
- Iterative multiply: cycle XLEN+2 (34 for XLEN=32).
- Divide: cycle XLEN+2.
- Special-case divide: cycle 1.
- Fast multiply (see Configuration): cycle 2.
- result and rd_out hold their values after DONE until the next accept.
- Back-to-back: a new start is accepted in the cycle after DONE at the earliest.

## Configuration
- MULDIV_FAST_MUL_EN defined: the accept cycle registers a single-cycle signed (XLEN+1)x(XLEN+1) product, then the FSM goes IDLE→FIXUP→DONE. The MUL state and its counter path are not compiled.
- Undefined: iterative shift-add multiplier as described above.
- Divide behaviour is identical in both configurations.

## Structure
- Package muldiv_pkg holds:
  - state enum (IDLE, MUL, DIV, FIXUP, DONE)
  - funct3 constants MULDIV_MUL…MULDIV_REMU
  - opcode constant for OP with funct7=0000001
- Sub-module muldiv_fixup, combinational: sign correction and result selection from accumulator, quotient, remainder, sign flags and funct3. The top level keeps the FSM, counter and datapath registers.

## Test plan
- MUL 7 × -3 (0xFFFFFFFD) → result 0xFFFFFFEB. done at cycle 34, or at cycle 2 with MULDIV_FAST_MUL_EN. stall high cycles 0–33.
- High-half modes:
  - MULH 0x80000000 × 0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF
- Division:
  - DIV -7/2 → 0xFFFFFFFD
  - REM -7/2 → 0xFFFFFFFF
  - DIVU 100/7 → 14
  - REMU 100/7 → 2
  - all with done at cycle 34 and rd_out = rd_in.
- Special cases, all with done at cycle 1:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
- Flush and back-to-back:
  - flush at cycle 10 of a DIV → IDLE at cycle 11, no done pulse, stall 0.
  - A start at cycle 11 is accepted normally.
  - flush together with start in IDLE → no accept.
- Reset mid-operation: rst_n low at cycle 5 of a MUL → immediately state IDLE, done/stall/busy 0, result 0, rd_out 0. After release, no done pulse appears.
